// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the pipeline registers of the 5-stage core.
//   XLEN        width of pc and instruction words
//   NOP_INSTR   addi x0,x0,0, shown to decode when no real word is held
//   CNT_W       default width of performance counters
//   fetch_word_t {valid, pc, instr}, the word passed between pipeline stages
//   buf_state_e  occupancy of a two-entry pipeline buffer
//   instr_rs1/instr_rs2/instr_rd  register-field extraction helpers
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          CNT_W     = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_word_t;

    // Encoding is {main_valid, skid_valid}; 2'b01 is never reached.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_e;

    function automatic logic [4:0] instr_rs1(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] instr_rs2(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] instr_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/skid_buffer2.sv
// skid_buffer2: two-entry (main + skid) buffer with a valid/ready input side.
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid/in_pc/in_instr/in_ready   upstream handshake
//   stall          downstream is not taking the main word this cycle
//   clear          drop everything held, including a word offered this cycle
//   main_valid/main_pc/main_instr      the word at the head of the buffer
// in_ready comes straight from a flop so the upstream handshake never sees
// a combinational path from stall or clear.
module skid_buffer2
    import core_pkg::*;
#(
    parameter int          XLEN        = core_pkg::XLEN,
    parameter logic [31:0] EMPTY_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    input  logic            stall,
    input  logic            clear,
    output logic            main_valid,
    output logic [XLEN-1:0] main_pc,
    output logic [31:0]     main_instr
);

    buf_state_e      state_q, state_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d;
    logic [31:0]     main_instr_q, main_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            accept;
    logic            consume;

    assign main_valid = (state_q != BUF_EMPTY);
    assign in_ready   = (state_q != BUF_FULL);
    assign main_pc    = main_pc_q;
    assign main_instr = main_instr_q;

    assign accept  = in_valid & in_ready;
    assign consume = main_valid & ~stall;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (clear) begin
            // pc is left alone so the last decode pc stays visible for debug.
            state_d      = BUF_EMPTY;
            main_instr_d = EMPTY_INSTR;
            skid_instr_d = EMPTY_INSTR;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d      = BUF_ONE;
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end
                end
                BUF_ONE: begin
                    if (consume && accept) begin
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end else if (consume) begin
                        state_d      = BUF_EMPTY;
                        main_instr_d = EMPTY_INSTR;
                    end else if (accept) begin
                        state_d      = BUF_FULL;
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                    end
                end
                BUF_FULL: begin
                    if (consume) begin
                        state_d      = BUF_ONE;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        skid_instr_d = EMPTY_INSTR;
                    end
                end
                default: begin
                    state_d      = BUF_EMPTY;
                    main_instr_d = EMPTY_INSTR;
                    skid_instr_d = EMPTY_INSTR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BUF_EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= EMPTY_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= EMPTY_INSTR;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch-to-decode pipeline register.
//   clk, rst_n                     clock, asynchronous active-low reset
//   fetch_valid/fetch_pc/fetch_instr/fetch_ready   word from fetch
//   id_stall                       hazard unit holds decode
//   flush                          taken branch/jump, squash all held words
//   id_valid/id_pc/id_instr        decode word (NOP when not valid)
//   id_rs1/id_rs2/id_rd            register fields of id_instr
//   stall_cnt                      saturating count of stalled valid cycles
module if_id_stage
    import core_pkg::*;
#(
    parameter int          XLEN      = core_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR,
    parameter int          CNT_W     = core_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic [31:0]      fetch_instr,
    output logic             fetch_ready,
    input  logic             id_stall,
    input  logic             flush,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [31:0]      id_instr,
    output logic [4:0]       id_rs1,
    output logic [4:0]       id_rs2,
    output logic [4:0]       id_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             main_valid;
    logic [31:0]      main_instr;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    skid_buffer2 #(
        .XLEN        (XLEN),
        .EMPTY_INSTR (NOP_INSTR)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (fetch_valid),
        .in_pc      (fetch_pc),
        .in_instr   (fetch_instr),
        .in_ready   (fetch_ready),
        .stall      (id_stall),
        .clear      (flush),
        .main_valid (main_valid),
        .main_pc    (id_pc),
        .main_instr (main_instr)
    );

    // The buffer already stores NOP when empty; the mux keeps the guarantee
    // local so decode can never see a stale instruction.
    assign id_valid  = main_valid;
    assign id_instr  = main_valid ? main_instr : NOP_INSTR;
    assign id_rs1    = instr_rs1(id_instr);
    assign id_rs2    = instr_rs2(id_instr);
    assign id_rd     = instr_rd(id_instr);
    assign stall_cnt = stall_cnt_q;

    // A flushed cycle is not a real stall, and the counter never wraps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid && id_stall && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: a queue model of the held words plus
// a table of hand-derived expectations, with a CNT_W=4 copy for saturation.
module tb_if_id_stage;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;
   logic        id_stall;
   logic        flush;

   logic        fetch_ready, id_valid;
   logic [31:0] id_pc, id_instr;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] stall_cnt;

   logic        s_fetch_ready, s_id_valid;
   logic [31:0] s_id_pc, s_id_instr;
   logic [4:0]  s_id_rs1, s_id_rs2, s_id_rd;
   logic [3:0]  s_stall_cnt;

   if_id_stage dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
      .fetch_ready(fetch_ready), .id_stall(id_stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .stall_cnt(stall_cnt)
   );

   if_id_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
      .fetch_ready(s_fetch_ready), .id_stall(id_stall), .flush(flush),
      .id_valid(s_id_valid), .id_pc(s_id_pc), .id_instr(s_id_instr),
      .id_rs1(s_id_rs1), .id_rs2(s_id_rs2), .id_rd(s_id_rd), .stall_cnt(s_stall_cnt)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } word_t;

   typedef struct {
      logic        fv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        stall;
      logic        fl;
      logic        eValid;
      logic [31:0] ePc;
      logic        eReady;
      logic [31:0] eCnt;
   } vec_t;

   word_t       sb[$];
   logic [31:0] mPc;
   logic [31:0] mCnt;
   logic [3:0]  mCnt4;
   int          errors = 0;
   int          checks = 0;
   vec_t        vecs[16];

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Compares every output against the queue model.
   task automatic checkOutput(input string tag);
      logic [31:0] wInstr;
      wInstr = (sb.size() > 0) ? sb[0].instr : NOP_INSTR;
      check32({tag, ".ready"}, {31'd0, fetch_ready}, {31'd0, sb.size() < 2});
      check32({tag, ".valid"}, {31'd0, id_valid}, {31'd0, sb.size() > 0});
      check32({tag, ".pc"}, id_pc, mPc);
      check32({tag, ".instr"}, id_instr, wInstr);
      check32({tag, ".rs1"}, {27'd0, id_rs1}, {27'd0, wInstr[19:15]});
      check32({tag, ".rs2"}, {27'd0, id_rs2}, {27'd0, wInstr[24:20]});
      check32({tag, ".rd"}, {27'd0, id_rd}, {27'd0, wInstr[11:7]});
      check32({tag, ".cnt"}, stall_cnt, mCnt);
      check32({tag, ".cnt4"}, {28'd0, s_stall_cnt}, {28'd0, mCnt4});
      check32({tag, ".valid4"}, {31'd0, s_id_valid}, {31'd0, sb.size() > 0});
   endtask

   // Drives one cycle of inputs from a negedge, steps the model across the
   // posedge, then checks at the following negedge.
   task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                                input logic stall, input logic fl, input string tag);
      logic  accept, consume, stalled;
      word_t w;
      fetch_valid = fv;
      fetch_pc    = pc;
      fetch_instr = instr;
      id_stall    = stall;
      flush       = fl;
      accept  = fv && (sb.size() < 2);
      consume = (sb.size() > 0) && !stall;
      stalled = (sb.size() > 0) && stall && !fl;
      @(posedge clk);
      if (fl) begin
         sb.delete();
      end else begin
         if (consume) void'(sb.pop_front());
         if (accept) begin
            w.pc    = pc;
            w.instr = instr;
            sb.push_back(w);
         end
      end
      if (sb.size() > 0) mPc = sb[0].pc;
      if (stalled) begin
         if (mCnt != 32'hFFFF_FFFF) mCnt++;
         if (mCnt4 != 4'hF) mCnt4++;
      end
      @(negedge clk);
      checkOutput(tag);
   endtask

   task automatic resetModel();
      sb.delete();
      mPc   = '0;
      mCnt  = '0;
      mCnt4 = '0;
   endtask

   initial begin
      // Hand-derived expectations: {fv, pc, instr, stall, flush, valid, pc, ready, cnt}
      vecs[0]  = '{1'b1, 32'h00, 32'h00100093, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'd0};
      vecs[1]  = '{1'b1, 32'h04, 32'h00200113, 1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'd0};
      vecs[2]  = '{1'b1, 32'h08, 32'h00308193, 1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'd0};
      vecs[3]  = '{1'b1, 32'h10, 32'h00410213, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'd0};
      vecs[4]  = '{1'b1, 32'h14, 32'h00518293, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'd1};
      vecs[5]  = '{1'b1, 32'h18, 32'h00620313, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'd2};
      vecs[6]  = '{1'b1, 32'h18, 32'h00620313, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'd3};
      vecs[7]  = '{1'b0, 32'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'd3};
      vecs[8]  = '{1'b0, 32'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'd3};
      vecs[9]  = '{1'b1, 32'h20, 32'h00728393, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'd3};
      vecs[10] = '{1'b1, 32'h24, 32'h00830413, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'd4};
      vecs[11] = '{1'b1, 32'h28, 32'h00938493, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'd4};
      vecs[12] = '{1'b1, 32'h2C, 32'h00A40513, 1'b0, 1'b0, 1'b1, 32'h2C, 1'b1, 32'd4};
      vecs[13] = '{1'b1, 32'h30, 32'h00B48593, 1'b1, 1'b1, 1'b0, 32'h2C, 1'b1, 32'd4};
      vecs[14] = '{1'b1, 32'h40, 32'h00B50533, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'd4};
      vecs[15] = '{1'b0, 32'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 32'd4};

      fetch_valid = 1'b0;
      fetch_pc    = '0;
      fetch_instr = '0;
      id_stall    = 1'b0;
      flush       = 1'b0;
      rst_n       = 1'b1;
      resetModel();

      // Reset asserted before any clock edge must already show reset values.
      #1 rst_n = 1'b0;
      #3;
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset");

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].stall, vecs[i].fl,
                       $sformatf("vec%0d", i));
         check32($sformatf("vec%0d.tvalid", i), {31'd0, id_valid}, {31'd0, vecs[i].eValid});
         check32($sformatf("vec%0d.tpc", i), id_pc, vecs[i].ePc);
         check32($sformatf("vec%0d.tready", i), {31'd0, fetch_ready}, {31'd0, vecs[i].eReady});
         check32($sformatf("vec%0d.tcnt", i), stall_cnt, vecs[i].eCnt);
         if (i == 11) check32("flush.nop", id_instr, 32'h00000013);
         if (i == 14) begin
            check32("add.rs1", {27'd0, id_rs1}, 32'd10);
            check32("add.rs2", {27'd0, id_rs2}, 32'd11);
            check32("add.rd", {27'd0, id_rd}, 32'd10);
         end
      end

      // Twenty stalled cycles with a valid decode word: the 4-bit copy pins at 15.
      applyStimulus(1'b1, 32'h50, 32'h01000613, 1'b0, 1'b0, "sat_load");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, $sformatf("sat%0d", i));
      end
      check32("cnt4.sat", {28'd0, s_stall_cnt}, 32'd15);
      check32("cnt.wide", stall_cnt, 32'd24);

      // Fill both entries, then pull reset between clock edges.
      applyStimulus(1'b1, 32'h60, 32'h01100693, 1'b0, 1'b0, "mid_a");
      applyStimulus(1'b1, 32'h64, 32'h01200713, 1'b1, 1'b0, "mid_b");
      check32("mid.full_ready", {31'd0, fetch_ready}, 32'd0);
      #2 rst_n = 1'b0;
      fetch_valid = 1'b0;
      id_stall    = 1'b0;
      #1;
      resetModel();
      checkOutput("async_rst");
      check32("async_rst.pc4", s_id_pc, 32'h0);
      check32("async_rst.instr4", s_id_instr, NOP_INSTR);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'h70, 32'h01300793, 1'b0, 1'b0, "after_rst");
      check32("after_rst.pc", id_pc, 32'h70);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
